// File: rtl/reg64_access_pkg.sv
// Shared types and constants for the 64-bit register access controller.
// State encoding is kept as plain localparams so the same values can be reused
// by tools and legacy code that predate enum support.
package reg64_access_pkg;

    localparam int unsigned DATA_W_DEFAULT = 64;

    // cmd_write encoding
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_PRIME = 3'd0;
    localparam state_t ST_IDLE  = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_RESP  = 3'd4;

endpackage

// File: rtl/reg64_access_ctrl_if.sv
// Command and response channels of the register access controller.
// master = host/sequencer side, slave = controller side.
interface reg64_access_ctrl_if
    import reg64_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/reg64_onehot_dec.sv
// Address to one-hot target enable decoder with a range check.
// The one-hot output is zero when disabled or when the address has no target.
module reg64_onehot_dec
    import reg64_access_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o,
    output logic                in_range_o
);

    // Range check and gated one-hot decode
    always_comb begin
        in_range_o = (32'(addr_i) < NUM_REGS);
        onehot_o   = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            onehot_o[i] = en_i && in_range_o && (32'(addr_i) == i);
        end
    end

endmodule

// File: rtl/reg64_access_ctrl.sv
// Initiator for a bank of 64-bit register targets with one-hot strobes.
// Takes one command at a time over cmd valid/ready, strobes the addressed
// target, and returns status and read data over rsp valid/ready.
// Optional build macro READBACK_VERIFY_EN: every write is followed by a read of
// the same target and the response reports a readback mismatch.
module reg64_access_ctrl
    import reg64_access_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    reg64_access_ctrl_if.slave  bus,
    output logic [NUM_REGS-1:0] reg_en,
    output logic                reg_read,
    output logic [DATA_W-1:0]   reg_wdata,
    input  logic [DATA_W-1:0]   reg_rdata
);

    localparam int unsigned CNT_W = 4;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rb_q, rb_d;      // second (readback) strobe of a write
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic                active;
    logic [ADDR_W-1:0]   dec_addr;
    logic [NUM_REGS-1:0] dec_onehot;
    logic                dec_in_range;

    // Outputs are held low while Rst is asserted so that the PRIME strobe only
    // shows in the first cycle after release.
    assign active   = ~Rst;
    assign dec_addr = (state_q == ST_ISSUE) ? addr_q : bus.cmd_addr;

    reg64_onehot_dec #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .addr_i     (dec_addr),
        .en_i       (active && (state_q == ST_ISSUE)),
        .onehot_o   (dec_onehot),
        .in_range_o (dec_in_range)
    );

    // Next-state: command capture, strobe sequencing, latency count, response
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rb_d    = rb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_PRIME: state_d = ST_IDLE;
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    write_d = bus.cmd_write;
                    wdata_d = bus.cmd_wdata;
                    rb_d    = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (dec_in_range) begin
                        state_d = ST_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                if ((write_q == OP_WRITE) && !rb_q) begin
`ifdef READBACK_VERIFY_EN
                    rb_d = 1'b1;
`else
                    state_d = ST_RESP;
`endif
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = reg_rdata;
`ifdef READBACK_VERIFY_EN
                    err_d = (write_q == OP_WRITE) && (reg_rdata != wdata_q);
`endif
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_PRIME;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_PRIME;
            addr_q  <= '0;
            write_q <= OP_READ;
            wdata_q <= '0;
            cnt_q   <= '0;
            rb_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rb_q    <= rb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Target strobes and channel outputs
    always_comb begin
        reg_en        = (active && (state_q == ST_PRIME)) ? '1 : dec_onehot;
        reg_read      = active && ((state_q == ST_PRIME) ||
                        ((state_q == ST_ISSUE) && ((write_q == OP_READ) || rb_q)));
        reg_wdata     = active ? wdata_q : '0;
        bus.cmd_ready = active && (state_q == ST_IDLE);
        bus.rsp_valid = active && (state_q == ST_RESP);
        bus.rsp_rdata = active ? rdata_q : '0;
        bus.rsp_err   = active && err_q;
    end

endmodule

// File: tb/tb_reg64_access_ctrl.sv
// Self-checking bench for reg64_access_ctrl: directed table, hand sequences for
// reset/backpressure, and random commands against a behavioural bank model.
module tb_reg64_access_ctrl;
    import reg64_access_pkg::*;

    localparam int unsigned NUM_REGS = 6;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned RD_LAT   = 2;
`ifdef READBACK_VERIFY_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg64_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [NUM_REGS-1:0] reg_en;
    logic                reg_read;
    logic [DATA_W-1:0]   reg_wdata;
    logic [DATA_W-1:0]   reg_rdata;

    reg64_access_ctrl #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT)
    ) u_dut (
        .Clk       (clk),
        .Rst       (rst),
        .bus       (bus),
        .reg_en    (reg_en),
        .reg_read  (reg_read),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    // Target bank: drops its first enabled cycle, reads return data RD_LAT
    // cycles after the strobe edge, random junk otherwise.
    logic [DATA_W-1:0]   mem  [NUM_REGS];
    logic [DATA_W-1:0]   pipe [RD_LAT];
    logic [NUM_REGS-1:0] stuck;
    logic                primed;
    int                  n_strobes  = 0;
    int                  n_multihot = 0;
    logic [NUM_REGS-1:0] last_en;
    logic                last_read;
    int                  sel_idx;

    always_comb begin
        sel_idx = 0;
        for (int i = 0; i < NUM_REGS; i++) if (reg_en[i]) sel_idx = i;
    end

    always @(posedge clk) begin
        if (rst) begin
            primed <= 1'b0;
        end else if (reg_en != '0) begin
            if (!primed) begin
                primed <= 1'b1;
            end else begin
                n_strobes <= n_strobes + 1;
                last_en   <= reg_en;
                last_read <= reg_read;
                if ($countones(reg_en) != 1) n_multihot <= n_multihot + 1;
                if (!reg_read) mem[sel_idx] <= reg_wdata;
            end
        end
        if (!rst && primed && (reg_en != '0) && reg_read)
            pipe[0] <= stuck[sel_idx] ? '0 : mem[sel_idx];
        else
            pipe[0] <= {$urandom, $urandom};
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end

    assign reg_rdata = pipe[RD_LAT-1];

    // Reference model: what each command must return, from the rules alone
    logic [DATA_W-1:0] ref_mem [NUM_REGS];

    task automatic model(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, output int lat, output int strobes,
                         output logic err, output logic [DATA_W-1:0] rd);
        if (int'(addr) >= int'(NUM_REGS)) begin
            lat = 1; strobes = 0; err = 1'b1; rd = '0;
        end else if (!wr) begin
            lat = 2 + int'(RD_LAT); strobes = 1; err = 1'b0;
            rd = stuck[addr] ? '0 : ref_mem[addr];
        end else begin
            ref_mem[addr] = wd;
            if (RB) begin
                lat = 3 + int'(RD_LAT); strobes = 2;
                rd = stuck[addr] ? '0 : wd;
                err = (rd != wd);
            end else begin
                lat = 2; strobes = 1; err = 1'b0; rd = '0;
            end
        end
    endtask

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one command from mid-IDLE and take its response; optionally queue the
    // next command while the response is held off.
    task automatic run_cmd(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input int hold,
                           input bit use_tab, input logic tab_err, input logic [DATA_W-1:0] tab_rd,
                           input bit queue, input logic q_wr, input logic [ADDR_W-1:0] q_addr,
                           input logic [DATA_W-1:0] q_wd);
        int k, lat, s0, e_lat, e_str;
        logic e_err;
        logic [DATA_W-1:0] e_rd;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        k = 0;
        while (!bus.cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_in_idle", 64'(k), 64'd0);
        s0 = n_strobes;
        model(wr, addr, wd, e_lat, e_str, e_err, e_rd);
        if (use_tab) begin
            e_err = tab_err;
            e_rd  = tab_rd;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", 64'(lat), 64'(e_lat));
        chk("rsp_err", 64'(bus.rsp_err), 64'(e_err));
        chk("rsp_rdata", bus.rsp_rdata, e_rd);
        if (queue) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = q_wr;
            bus.cmd_addr  = q_addr;
            bus.cmd_wdata = q_wd;
        end
        for (int i = 0; i < hold; i++) begin
            chk("cmd_ready_held_off", 64'(bus.cmd_ready), 64'd0);
            @(negedge clk);
            chk("rsp_valid_stable", 64'(bus.rsp_valid), 64'd1);
            chk("rsp_err_stable", 64'(bus.rsp_err), 64'(e_err));
            chk("rsp_rdata_stable", bus.rsp_rdata, e_rd);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_dropped", 64'(bus.rsp_valid), 64'd0);
        chk("cmd_ready_after_rsp", 64'(bus.cmd_ready), 64'd1);
        chk("strobe_count", 64'(n_strobes - s0), 64'(e_str));
    endtask

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        int                hold;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;

    vec_t tab [9];

    function automatic logic [DATA_W-1:0] wr_rd(input logic [DATA_W-1:0] wd);
        return RB ? wd : '0;
    endfunction

    initial begin
        logic              r_wr;
        logic [ADDR_W-1:0] r_addr;
        logic [DATA_W-1:0] r_wd;

        tab[0] = '{1'b0, 3'd3, 64'd0, 0, 1'b0, 64'hDEAD_BEEF_0123_4567};
        tab[1] = '{1'b0, 3'd7, 64'd0, 1, 1'b1, 64'd0};
        tab[2] = '{1'b1, 3'd0, 64'h1111_2222_3333_4444, 0, 1'b0,
                   wr_rd(64'h1111_2222_3333_4444)};
        tab[3] = '{1'b1, 3'd5, 64'hA5A5_5A5A_0F0F_F0F0, 3, 1'b0,
                   wr_rd(64'hA5A5_5A5A_0F0F_F0F0)};
        tab[4] = '{1'b0, 3'd0, 64'd0, 2, 1'b0, 64'h1111_2222_3333_4444};
        tab[5] = '{1'b0, 3'd5, 64'd0, 0, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0};
        tab[6] = '{1'b0, 3'd6, 64'd0, 0, 1'b1, 64'd0};
        tab[7] = '{1'b1, 3'd6, 64'hFFFF, 1, 1'b1, 64'd0};
        tab[8] = '{1'b0, 3'd3, 64'd0, 0, 1'b0, 64'hDEAD_BEEF_0123_4567};

        stuck         = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset, then a single PRIME strobe, then IDLE
        @(negedge clk);
        chk("reset_reg_en", 64'(reg_en), 64'd0);
        chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("prime_reg_en", 64'(reg_en), 64'h3F);
        chk("prime_reg_read", 64'(reg_read), 64'd1);
        chk("prime_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        chk("post_prime_reg_en", 64'(reg_en), 64'd0);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Give every target a known value
        for (int i = 0; i < int'(NUM_REGS); i++)
            run_cmd(1'b1, ADDR_W'(i), {$urandom, $urandom}, 0, 1'b0, 1'b0, '0,
                    1'b0, 1'b0, '0, '0);

        // Write addr 3 and check the strobe pattern
        run_cmd(1'b1, 3'd3, 64'hDEAD_BEEF_0123_4567, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("write3_reg_en", 64'(last_en), 64'h08);
        chk("write3_last_read", 64'(last_read), 64'(RB));

        for (int i = 0; i < 9; i++)
            run_cmd(tab[i].wr, tab[i].addr, tab[i].wd, tab[i].hold,
                    1'b1, tab[i].exp_err, tab[i].exp_rd, 1'b0, 1'b0, '0, '0);

        // Backpressure with a command queued behind the held response
        run_cmd(1'b0, 3'd3, '0, 5, 1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd5, '0);
        run_cmd(1'b0, 3'd5, '0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Reset during WAIT: no response, PRIME strobe again
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 3'd0;
        chk("rst_test_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("wait_no_strobe", 64'(reg_en), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("rst_mid_reg_en", 64'(reg_en), 64'd0);
        rst = 1'b0;
        #1;
        chk("reprime_reg_en", 64'(reg_en), 64'h3F);
        chk("reprime_reg_read", 64'(reg_read), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("aborted_no_rsp", 64'(bus.rsp_valid), 64'd0);
            chk("aborted_idle_ready", 64'(bus.cmd_ready), 64'd1);
        end

        // Random commands, including out-of-range addresses
        for (int n = 0; n < 120; n++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = ADDR_W'($urandom_range(0, 7));
            r_wd   = {$urandom, $urandom};
            run_cmd(r_wr, r_addr, r_wd, int'($urandom_range(0, 2)), 1'b0, 1'b0, '0,
                    1'b0, 1'b0, '0, '0);
        end

        // Target forced to read back zero, and a healthy target
        stuck[2] = 1'b1;
        run_cmd(1'b1, 3'd2, 64'h1, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        run_cmd(1'b1, 3'd4, 64'h1, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        run_cmd(1'b0, 3'd2, '0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        stuck = '0;
        run_cmd(1'b0, 3'd2, '0, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);

        chk("multihot_strobes", 64'(n_multihot), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
